// File: rtl/bp_table_sched_if.sv
// Request/response bundle between the branch-table scheduler and its
// decoder, fetch, instruction-queue, dispatcher and reorder-buffer neighbours.
interface bp_table_sched_if #(
  parameter int unsigned AW = 32
) ();
  logic          decoder_bp_en_in;
  logic [AW-1:0] decoder_bp_pc_in;
  logic [AW-1:0] decoder_bp_target_in;
  logic          bp_decoder_stall_out;
  logic          bp_if_en_out;
  logic [AW-1:0] bp_if_pc_out;
  logic          bp_dispatcher_taken_out;
  logic          bp_instqueue_rst_out;
  logic          rob_bp_en_in;
  logic          rob_bp_correct_in;
  logic [AW-1:0] rob_bp_pc_in;
  logic          bp_rob_full_out;

  modport master (
    output decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
    output rob_bp_en_in, rob_bp_correct_in, rob_bp_pc_in,
    input  bp_decoder_stall_out, bp_if_en_out, bp_if_pc_out,
    input  bp_dispatcher_taken_out, bp_instqueue_rst_out, bp_rob_full_out
  );

  modport slave (
    input  decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
    input  rob_bp_en_in, rob_bp_correct_in, rob_bp_pc_in,
    output bp_decoder_stall_out, bp_if_en_out, bp_if_pc_out,
    output bp_dispatcher_taken_out, bp_instqueue_rst_out, bp_rob_full_out
  );
endinterface

// File: rtl/bp_table_sched.sv
// Single-port 2-bit branch-history table shared between decoder lookups and
// queued ROB updates, with a starvation guard that forces pending updates through.
module bp_table_sched #(
  parameter int unsigned INDEX_W      = 7,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned AW           = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  bp_table_sched_if.slave  bus
);
  localparam int unsigned TBL = 1 << INDEX_W;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);

  logic [1:0]         tbl_q [TBL];
  logic [INDEX_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic               fifo_cor_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               if_en_q, if_en_d;
  logic [AW-1:0]      if_pc_q, if_pc_d;
  logic               taken_q, taken_d;

  logic               full, upd_pending, upd_grant, lookup_grant, push, pred;
  logic [INDEX_W-1:0] lk_idx, head_idx;
  logic [1:0]         head_ctr, upd_val;

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic correct);
    logic [1:0] n;
    if (correct) n = c[1] ? ((c == 2'b11) ? 2'b11 : c + 2'b01)
                          : ((c == 2'b00) ? 2'b00 : c - 2'b01);
    else         n = c[1] ? c - 2'b01 : c + 2'b01;
    return n;
  endfunction

  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign upd_pending  = (count_q != '0);
  assign upd_grant    = rdy_in && upd_pending &&
                        (!bus.decoder_bp_en_in || full || (starve_q >= SW'(STARVE_LIMIT)));
  assign lookup_grant = rdy_in && bus.decoder_bp_en_in && !upd_grant;
  assign push         = rdy_in && bus.rob_bp_en_in && !full;

  assign lk_idx   = bus.decoder_bp_pc_in[INDEX_W+1:2];
  assign pred     = tbl_q[lk_idx][1];
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_ctr = tbl_q[head_idx];
  assign upd_val  = next_ctr(head_ctr, fifo_cor_q[rd_ptr_q]);

  assign bus.bp_decoder_stall_out    = bus.decoder_bp_en_in && !lookup_grant;
  assign bus.bp_rob_full_out         = full;
  assign bus.bp_if_en_out            = if_en_q;
  assign bus.bp_if_pc_out            = if_pc_q;
  assign bus.bp_dispatcher_taken_out = taken_q;
  assign bus.bp_instqueue_rst_out    = taken_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if_en_d  = if_en_q;
    if_pc_d  = if_pc_q;
    taken_d  = taken_q;
    if (rdy_in) begin
      if (push)      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (upd_grant) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, upd_grant})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (upd_grant || !upd_pending)
        starve_d = '0;
      else if (lookup_grant && (starve_q < SW'(STARVE_LIMIT)))
        starve_d = starve_q + SW'(1);
      if_en_d = lookup_grant;
      taken_d = lookup_grant && pred;
      if (lookup_grant)
        if_pc_d = pred ? bus.decoder_bp_target_in : bus.decoder_bp_pc_in + AW'(4);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < TBL; i++) tbl_q[i] <= 2'b01;
    end else if (upd_grant) begin
      tbl_q[head_idx] <= upd_val;
    end
  end

  // Entry storage needs no reset: validity is tracked solely by count_q.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= bus.rob_bp_pc_in[INDEX_W+1:2];
      fifo_cor_q[wr_ptr_q] <= bus.rob_bp_correct_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      if_en_q  <= 1'b0;
      if_pc_q  <= '0;
      taken_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if_en_q  <= if_en_d;
      if_pc_q  <= if_pc_d;
      taken_q  <= taken_d;
    end
  end
endmodule

// File: tb/tb_bp_table_sched.sv
// Randomized and directed checks of bp_table_sched against a queue/array reference model.
module tb_bp_table_sched;
  localparam int FD = 4;
  localparam int SL = 8;
  localparam int IW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  bp_table_sched_if #(.AW(32)) bus ();

  bp_table_sched #(
    .INDEX_W(IW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL), .AW(32)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] pc; bit correct; } upd_t;
  int          ctr [1 << IW];
  upd_t        pq [$];
  int          starve;
  bit          m_en, m_taken;
  logic [31:0] m_pc;
  bit          last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << IW); i++) ctr[i] = 1;
    pq.delete();
    starve = 0;
    m_en = 0; m_taken = 0; m_pc = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_en"},    bus.bp_if_en_out, m_en);
    check({pfx, "_pc"},    bus.bp_if_pc_out, m_pc);
    check({pfx, "_taken"}, bus.bp_dispatcher_taken_out, m_taken);
    check({pfx, "_iqrst"}, bus.bp_instqueue_rst_out, m_taken);
    check({pfx, "_full"},  bus.bp_rob_full_out, pq.size() == FD);
  endtask

  task automatic drive(input bit den, input logic [31:0] dpc, input logic [31:0] dtgt,
                       input bit ren, input bit rcor, input logic [31:0] rpc);
    bus.decoder_bp_en_in     = den;
    bus.decoder_bp_pc_in     = dpc;
    bus.decoder_bp_target_in = dtgt;
    bus.rob_bp_en_in         = ren;
    bus.rob_bp_correct_in    = rcor;
    bus.rob_bp_pc_in         = rpc;
  endtask

  // One clock: starts just after a negedge with inputs already driven.
  task automatic cycle();
    bit pend, full, ug, lg, den;
    int idx, c;
    upd_t e;
    #1;
    den  = bus.decoder_bp_en_in;
    pend = pq.size() != 0;
    full = pq.size() == FD;
    ug   = rdy && pend && (!den || full || starve >= SL);
    lg   = rdy && den && !ug;
    last_stall = den && !lg;
    check("stall", bus.bp_decoder_stall_out, last_stall);
    check("full_pre", bus.bp_rob_full_out, full);
    @(posedge clk);
    if (rdy) begin
      if (lg) begin
        idx     = int'(bus.decoder_bp_pc_in / 4) % (1 << IW);
        m_en    = 1;
        m_taken = ctr[idx] >= 2;
        m_pc    = m_taken ? bus.decoder_bp_target_in : bus.decoder_bp_pc_in + 32'd4;
      end else begin
        m_en = 0; m_taken = 0;
      end
      if (ug) begin
        e   = pq.pop_front();
        idx = int'(e.pc / 4) % (1 << IW);
        c   = ctr[idx];
        if (e.correct) c = (c >= 2) ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        else           c = (c >= 2) ? c - 1 : c + 1;
        ctr[idx] = c;
      end
      if (bus.rob_bp_en_in && !full) begin
        e.pc = bus.rob_bp_pc_in; e.correct = bus.rob_bp_correct_in;
        pq.push_back(e);
      end
      if (ug || !pend) starve = 0;
      else if (lg && starve < SL) starve++;
    end
    #1;
    check_outputs("post");
    @(negedge clk);
  endtask

  initial begin
    int grants;
    bit done;
    drive(0, '0, '0, 0, 0, '0);
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: cold lookup predicts not-taken
    drive(1, 32'h100, 32'h200, 0, 0, '0);
    cycle();
    check("t1_stall", last_stall, 1'b0);
    check("t1_en", bus.bp_if_en_out, 1'b1);
    check("t1_pc", bus.bp_if_pc_out, 32'h104);
    check("t1_taken", bus.bp_dispatcher_taken_out, 1'b0);

    // 2: incorrect then correct -> counter 11, lookup taken
    drive(0, '0, '0, 1, 0, 32'h100); cycle();
    drive(0, '0, '0, 1, 1, 32'h100); cycle();
    drive(0, '0, '0, 0, 0, '0);      cycle();
    drive(1, 32'h100, 32'h200, 0, 0, '0); cycle();
    check("t2_pc", bus.bp_if_pc_out, 32'h200);
    check("t2_taken", bus.bp_dispatcher_taken_out, 1'b1);
    check("t2_iqrst", bus.bp_instqueue_rst_out, 1'b1);

    // 3: fill FIFO under continuous lookups
    for (int i = 0; i < FD; i++) begin
      drive(1, 32'h400 + 32'(i * 4), 32'h800, 1, i[0], 32'h500 + 32'(i * 4));
      cycle();
    end
    check("t3_full", bus.bp_rob_full_out, 1'b1);
    drive(1, 32'h400, 32'h800, 0, 0, '0);
    cycle();
    check("t3_stall", last_stall, 1'b1);
    check("t3_full_drop", bus.bp_rob_full_out, 1'b0);
    drive(0, '0, '0, 0, 0, '0);
    for (int i = 0; i < FD; i++) cycle();

    // 4: starvation guard
    drive(1, 32'h600, 32'h900, 1, 1, 32'h700);
    cycle();
    drive(1, 32'h600, 32'h900, 0, 0, '0);
    grants = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (last_stall) done = 1; else grants++;
    end
    check("t4_grants", grants, SL);
    check("t4_stalled", done, 1'b1);
    check("t4_starve", starve, 0);

    // 5: global hold
    drive(1, 32'h100, 32'h200, 1, 0, 32'h100);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_stall", last_stall, 1'b1);
    end
    rdy = 1'b1;
    drive(0, '0, '0, 0, 0, '0);
    cycle();

    // 6: reset with pending updates
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h1000, 32'h2000, 1, 0, 32'h1000);
      cycle();
    end
    drive(0, '0, '0, 0, 0, '0);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_outputs("t6");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h1000, 32'h2000, 0, 0, '0);
    cycle();
    check("t6_cold_pc", bus.bp_if_pc_out, 32'h1004);

    // Random mix on a small set of aliased indices
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 2) != 0,
            32'h1000 + 32'($urandom_range(0, 5) * 4) + (($urandom_range(0, 1) != 0) ? 32'h200 : 32'h0),
            $urandom & 32'hffff_fffc,
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            32'h1000 + 32'($urandom_range(0, 5) * 4));
      if (i == 397) drive(1, 32'hffff_fffc, 32'h40, 0, 0, '0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
